m2vside_fifo: RTL

Parametrised side-information stage that replaces the single-entry block_start latch between the side-info producer and m2vidct/m2vside4. It holds up to DEPTH per-block side-info records in a FIFO, so the header/VLD side can run ahead of the IDCT. Each block_start pulse pops the oldest record into registered outputs. The block also adds flush, occupancy reporting and sticky underrun detection.

---
 rtl/m2v_side_pkg.sv | 40 ++++
 rtl/m2vside_fifo_mem.sv | 27 ++
 rtl/m2vside_fifo.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/m2v_side_pkg.sv
// Shared side-info record layout: default field widths, packed record width
// and bit offsets used to pack/unpack a side-info record.
package m2v_side_pkg;

    localparam int MVH_W_DEF = 16;
    localparam int MVV_W_DEF = 15;
    localparam int MBX_W_DEF = 6;
    localparam int MBY_W_DEF = 5;

    // Low six bits of a record: {mb_intra, block[2:0], coded, enable}
    localparam int FLAG_W     = 6;
    localparam int ENABLE_OFS = 0;
    localparam int CODED_OFS  = 1;
    localparam int BLOCK_OFS  = 2;
    localparam int BLOCK_W    = 3;
    localparam int INTRA_OFS  = 5;

    function automatic int side_width(int mvh_w, int mvv_w, int mbx_w, int mby_w);
        return mvh_w + mvv_w + mbx_w + mby_w + FLAG_W;
    endfunction

    function automatic int mby_ofs();
        return FLAG_W;
    endfunction

    function automatic int mbx_ofs(int mby_w);
        return FLAG_W + mby_w;
    endfunction

    function automatic int mvv_ofs(int mbx_w, int mby_w);
        return FLAG_W + mby_w + mbx_w;
    endfunction

    function automatic int mvh_ofs(int mvv_w, int mbx_w, int mby_w);
        return FLAG_W + mby_w + mbx_w + mvv_w;
    endfunction

    localparam int SIDE_W = side_width(MVH_W_DEF, MVV_W_DEF, MBX_W_DEF, MBY_W_DEF);

endpackage

// File: rtl/m2vside_fifo_mem.sv
// Side-info record storage: one write port, one asynchronous read port.
// Storage is deliberately not reset; validity is tracked by the pointers.
module m2vside_fifo_mem #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 2,
    parameter int WIDTH      = 48
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write the incoming record into its slot
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/m2vside_fifo.sv
// Side-info FIFO between the header/VLD side and the IDCT. Each block_start
// pops the oldest record into registered outputs; adds flush, occupancy and
// sticky underrun reporting.
module m2vside_fifo
    import m2v_side_pkg::*;
#(
    parameter int MVH_WIDTH  = MVH_W_DEF,
    parameter int MVV_WIDTH  = MVV_W_DEF,
    parameter int MBX_WIDTH  = MBX_W_DEF,
    parameter int MBY_WIDTH  = MBY_W_DEF,
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [MVH_WIDTH-1:0]  in_mv_h,
    input  logic [MVV_WIDTH-1:0]  in_mv_v,
    input  logic [MBX_WIDTH-1:0]  in_mb_x,
    input  logic [MBY_WIDTH-1:0]  in_mb_y,
    input  logic                  in_mb_intra,
    input  logic                  in_coded,
    input  logic                  in_enable,
    input  logic [2:0]            in_block,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  block_start,
    input  logic                  flush,
    input  logic                  clear_err,
    output logic [MVH_WIDTH-1:0]  out_mv_h,
    output logic [MVV_WIDTH-1:0]  out_mv_v,
    output logic [MBX_WIDTH-1:0]  out_mb_x,
    output logic [MBY_WIDTH-1:0]  out_mb_y,
    output logic                  out_mb_intra,
    output logic [2:0]            out_block,
    output logic                  out_coded,
    output logic                  out_enable,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  underrun
);

    localparam int W       = side_width(MVH_WIDTH, MVV_WIDTH, MBX_WIDTH, MBY_WIDTH);
    localparam int MBY_OFS = mby_ofs();
    localparam int MBX_OFS = mbx_ofs(MBY_WIDTH);
    localparam int MVV_OFS = mvv_ofs(MBX_WIDTH, MBY_WIDTH);
    localparam int MVH_OFS = mvh_ofs(MVV_WIDTH, MBX_WIDTH, MBY_WIDTH);

    localparam logic [ADDR_WIDTH:0]   FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [W-1:0]          out_q, out_d;
    logic                  underrun_q, underrun_d;

    logic [W-1:0] wr_data;
    logic [W-1:0] rd_data;
    logic         push_en;
    logic         pop_en;
    logic         underrun_evt;

    assign wr_data = {in_mv_h, in_mv_v, in_mb_x, in_mb_y,
                      in_mb_intra, in_block, in_coded, in_enable};

    // in_ready comes from registered count only, never from block_start
    assign in_ready     = (count_q != FULL_CNT);
    assign push_en      = in_valid && in_ready && !flush;
    assign pop_en       = block_start && (count_q != '0) && !flush;
    assign underrun_evt = block_start && (count_q == '0) && !flush;

    m2vside_fifo_mem #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .WIDTH      (W)
    ) u_mem (
        .clk   (clk),
        .we    (push_en),
        .waddr (wr_ptr_q),
        .wdata (wr_data),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

    // Next-state for pointers, occupancy, output record and underrun flag
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        out_d      = out_q;
        underrun_d = underrun_q;

        if (flush) begin
            // Flush outranks everything, including clear_err
            wr_ptr_d              = '0;
            rd_ptr_d              = '0;
            count_d               = '0;
            out_d[ENABLE_OFS]     = 1'b0;
        end else begin
            if (push_en) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop_en) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
                out_d    = rd_data;
            end
            if (underrun_evt) begin
                out_d[ENABLE_OFS] = 1'b0;
            end
            case ({push_en, pop_en})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
            // A new underrun beats a simultaneous clear
            if (clear_err) begin
                underrun_d = 1'b0;
            end
            if (underrun_evt) begin
                underrun_d = 1'b1;
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            out_q      <= '0;
            underrun_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            out_q      <= out_d;
            underrun_q <= underrun_d;
        end
    end

    assign out_mv_h     = out_q[MVH_OFS +: MVH_WIDTH];
    assign out_mv_v     = out_q[MVV_OFS +: MVV_WIDTH];
    assign out_mb_x     = out_q[MBX_OFS +: MBX_WIDTH];
    assign out_mb_y     = out_q[MBY_OFS +: MBY_WIDTH];
    assign out_mb_intra = out_q[INTRA_OFS];
    assign out_block    = out_q[BLOCK_OFS +: BLOCK_W];
    assign out_coded    = out_q[CODED_OFS];
    assign out_enable   = out_q[ENABLE_OFS];
    assign level        = count_q;
    assign underrun     = underrun_q;

endmodule
